// File: rtl/serial_deser_pkg.sv
// Shared constants, state encoding and sizing helper for the serial_deser receiver.
package serial_deser_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_PAR   = 2'd2;

    // Counter must reach WIDTH (parity phase) without wrapping.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Output holding register for serial_deser: valid/ready handshake, overrun pulse and
// parity-error storage (parity storage only with SERIAL_DESER_PARITY_EN).
module deser_out_reg
    import serial_deser_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_word,
`ifdef SERIAL_DESER_PARITY_EN
    input  logic             i_perr,
    output logic             o_parity_err,
`endif
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_overrun;
    logic             w_free;

    // Slot is free when empty or being drained on this very edge.
    assign w_free = !r_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && !w_free;
            if (i_load && w_free) begin
                r_dout  <= i_word;
                r_valid <= 1'b1;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef SERIAL_DESER_PARITY_EN
    logic r_perr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perr <= 1'b0;
        end else if (i_load && w_free) begin
            r_perr <= i_perr;
        end
    end

    assign o_parity_err = r_perr;
`endif

    assign o_dout    = r_dout;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver: shifts qualified bits into WIDTH-bit words.
// Define SERIAL_DESER_PARITY_EN to add a trailing even-parity bit and the parity_err port.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sin,
    input  logic             i_sin_valid,
    input  logic             i_sync,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_busy,
`ifdef SERIAL_DESER_PARITY_EN
    output logic             o_parity_err,
`endif
    output logic             o_overrun
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_in;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_word;
    logic             w_load;
`ifdef SERIAL_DESER_PARITY_EN
    logic             w_perr;
`endif

    always_comb begin
        // The first received bit ends up at bit 0 (LSB-first) or WIDTH-1 (MSB-first).
        w_shift_in  = MSB_FIRST ? {r_shift[WIDTH-2:0], i_sin} : {i_sin, r_shift[WIDTH-1:1]};
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_word      = w_shift_in;
        w_load      = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
        w_perr      = 1'b0;
`endif
        if (i_sin_valid) begin
            if (i_sync || r_state == ST_IDLE) begin
                w_shift_nxt = w_shift_in;
                w_cnt_nxt   = CW'(1);
                w_state_nxt = ST_SHIFT;
            end else if (r_state == ST_SHIFT) begin
                w_shift_nxt = w_shift_in;
                if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_DESER_PARITY_EN
                    w_cnt_nxt   = CW'(WIDTH);
                    w_state_nxt = ST_PAR;
`else
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    w_load      = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
`ifdef SERIAL_DESER_PARITY_EN
            else begin
                // Parity bit: data already complete in the shift register.
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
                w_load      = 1'b1;
                w_word      = r_shift;
                w_perr      = ^r_shift ^ i_sin;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    assign o_busy = (r_state != ST_IDLE);

    deser_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (w_load),
        .i_word       (w_word),
`ifdef SERIAL_DESER_PARITY_EN
        .i_perr       (w_perr),
        .o_parity_err (o_parity_err),
`endif
        .i_ready      (i_dout_ready),
        .o_dout       (o_dout),
        .o_valid      (o_dout_valid),
        .o_overrun    (o_overrun)
    );

endmodule

// File: tb/tb_serial_deser.sv
// Randomized + directed bench for serial_deser: queue-based word model and scoreboard.
module tb_serial_deser;

    localparam int unsigned W = 8;
`ifdef SERIAL_DESER_PARITY_EN
    localparam int unsigned NB = W + 1;
`else
    localparam int unsigned NB = W;
`endif

    typedef struct {
        logic [W-1:0] lsb;
        logic [W-1:0] msb;
        logic         perr;
    } item_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sin, sin_valid, sync, ready;
    logic [W-1:0] dout0, dout1;
    logic         valid0, valid1, busy0, busy1, ovr0, ovr1;
`ifdef SERIAL_DESER_PARITY_EN
    logic         perr0, perr1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sin        (sin),
        .i_sin_valid  (sin_valid),
        .i_sync       (sync),
        .o_dout       (dout0),
        .o_dout_valid (valid0),
        .i_dout_ready (ready),
        .o_busy       (busy0),
`ifdef SERIAL_DESER_PARITY_EN
        .o_parity_err (perr0),
`endif
        .o_overrun    (ovr0)
    );

    serial_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sin        (sin),
        .i_sin_valid  (sin_valid),
        .i_sync       (sync),
        .o_dout       (dout1),
        .o_dout_valid (valid1),
        .i_dout_ready (ready),
        .o_busy       (busy1),
`ifdef SERIAL_DESER_PARITY_EN
        .o_parity_err (perr1),
`endif
        .o_overrun    (ovr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: bits collected per word in a queue, output slot tracked abstractly.
    logic  bits[$];
    item_t exp_q[$];
    logic  m_valid   = 1'b0;
    logic  exp_ovr   = 1'b0;
    logic  exp_busy  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits.delete();
            exp_q.delete();
            m_valid  = 1'b0;
            exp_ovr  = 1'b0;
            exp_busy = 1'b0;
        end else begin
            logic  complete;
            logic  free;
            item_t it;
            complete = 1'b0;
            it.lsb = '0;
            it.msb = '0;
            it.perr = 1'b0;
            if (sin_valid) begin
                if (sync) bits.delete();
                bits.push_back(sin);
                if (bits.size() == NB) begin
                    complete = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        it.lsb[i]     = bits[i];
                        it.msb[W-1-i] = bits[i];
                    end
                    for (int i = 0; i < NB; i++) it.perr = it.perr ^ bits[i];
                    bits.delete();
                end
            end
            free    = !m_valid || ready;
            exp_ovr = complete && !free;
            if (complete && free) begin
                m_valid = 1'b1;
                exp_q.push_back(it);
            end else if (ready) begin
                m_valid = 1'b0;
            end
            exp_busy = (bits.size() != 0);
        end
    end

    // Monitor: pops the scoreboard whenever the consumer takes a word.
    always @(negedge clk) begin
        if (rst_n) begin
            check("dout_valid", {31'd0, valid0}, {31'd0, m_valid});
            check("dout_valid_msb", {31'd0, valid1}, {31'd0, m_valid});
            check("busy", {31'd0, busy0}, {31'd0, exp_busy});
            check("overrun", {31'd0, ovr0}, {31'd0, exp_ovr});
            if (valid0 && ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'd1, 32'd0);
                end else begin
                    item_t it;
                    it = exp_q.pop_front();
                    check("word_lsb", {24'd0, dout0}, {24'd0, it.lsb});
                    check("word_msb", {24'd0, dout1}, {24'd0, it.msb});
`ifdef SERIAL_DESER_PARITY_EN
                    check("parity_err", {31'd0, perr0}, {31'd0, it.perr});
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sy);
        sin       = b;
        sin_valid = 1'b1;
        sync      = sy;
        tick();
        sin_valid = 1'b0;
        sync      = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] d, input int gap, input logic sy,
                             input logic rdy_last, input logic bad_par);
        logic [NB-1:0] frame;
        frame[W-1:0] = d;
`ifdef SERIAL_DESER_PARITY_EN
        frame[W] = ^d ^ bad_par;
`else
        if (bad_par) frame[0] = d[0];
`endif
        for (int i = 0; i < NB; i++) begin
            if (i > 0) repeat (gap) tick();
            if (rdy_last && i == NB - 1) ready = 1'b1;
            send_bit(frame[i], sy && i == 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, {24'd0, dout0}, 32'd0);
        check({tag, "_dout_msb"}, {24'd0, dout1}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid0}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy0}, 32'd0);
        check({tag, "_overrun"}, {31'd0, ovr0}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; ready = 1'b0;
        #3;
        check_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Basic word, LSB- and MSB-first views of bits 1,0,1,1,0,0,1,0.
        ready = 1'b1;
        send_word(8'h4D, 0, 1'b0, 1'b0, 1'b0);
        check("basic_lsb", {24'd0, dout0}, 32'h4D);
        check("basic_msb", {24'd0, dout1}, 32'hB2);
        check("basic_valid", {31'd0, valid0}, 32'd1);
        tick();
        check("basic_valid_one_cycle", {31'd0, valid0}, 32'd0);

        // Gaps between bits.
        send_word(8'h4D, 3, 1'b0, 1'b0, 1'b0);
        check("gap_lsb", {24'd0, dout0}, 32'h4D);
        tick();

        // Partial word discarded by sync.
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
        check("partial_busy", {31'd0, busy0}, 32'd1);
        send_word(8'hFF, 0, 1'b1, 1'b0, 1'b0);
        check("sync_word", {24'd0, dout0}, 32'hFF);
        check("sync_busy_done", {31'd0, busy0}, 32'd0);
        tick();

        // Backpressure: second word dropped.
        ready = 1'b0;
        send_word(8'h4D, 0, 1'b0, 1'b0, 1'b0);
        send_word(8'h12, 0, 1'b0, 1'b0, 1'b0);
        check("bp_overrun", {31'd0, ovr0}, 32'd1);
        check("bp_dout_kept", {24'd0, dout0}, 32'h4D);
        tick();
        check("bp_overrun_pulse", {31'd0, ovr0}, 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Accept coinciding with completion: replacement, no overrun.
        send_word(8'h4D, 0, 1'b0, 1'b0, 1'b0);
        send_word(8'h12, 0, 1'b0, 1'b1, 1'b0);
        check("replace_dout", {24'd0, dout0}, 32'h12);
        check("replace_valid", {31'd0, valid0}, 32'd1);
        check("replace_no_overrun", {31'd0, ovr0}, 32'd0);
        tick();

`ifdef SERIAL_DESER_PARITY_EN
        send_word(8'h4D, 0, 1'b0, 1'b0, 1'b0);
        check("parity_good", {31'd0, perr0}, 32'd0);
        tick();
        send_word(8'h4D, 0, 1'b0, 1'b0, 1'b1);
        check("parity_bad", {31'd0, perr0}, 32'd1);
        check("parity_bad_word", {24'd0, dout0}, 32'h4D);
        tick();
`endif

        // Asynchronous reset mid-word, then a clean word.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0);
        check("post_reset_word", {24'd0, dout0}, 32'hA5);
        tick();

        // Randomized traffic.
        repeat (600) begin
            sin       = 1'($urandom);
            sin_valid = ($urandom_range(0, 9) < 7);
            sync      = ($urandom_range(0, 29) == 0);
            ready     = ($urandom_range(0, 9) < 6);
            tick();
        end
        sin_valid = 1'b0;
        sync      = 1'b0;
        ready     = 1'b1;
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_deser.md
# serial_deser

- Serial-to-parallel receiver that assembles a bit-serial stream, one bit per qualified clock, into WIDTH-bit words.
- Completed words are presented on a valid/ready output port.
- It is the receiving end of the team's bit-select/register serial path: each `sin` bit is the registered `Q` of an upstream flip-flop stage.
- Sits between that serial link and any parallel consumer.

## Interface

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 0, bit order: 0 means the first received bit lands in dout[0]; 1 means it lands in dout[WIDTH-1].

Ports:
- clk  input  1  the only clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  `sin` is sampled on this edge.
- sync  input  1  start-of-word marker, qualified by `sin_valid`; any partial word is discarded.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  `dout` holds an unconsumed word.
- dout_ready  input  1  consumer accepts the word on an edge where `dout_valid` is also high.
- busy  output  1  a partial word is in progress (state SHIFT or PAR).
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- parity_err  output  1  parity result for the current `dout`; exists only with PARITY_EN.

## Operation

Reset values: all outputs 0, including `dout`, shift register, bit counter and state (IDLE).

States and transitions:
- IDLE: counter = 0.
  - `sin_valid` → shift the bit in, counter = 1, go to SHIFT.
  - Edge case WIDTH bits complete at once does not arise (WIDTH ≥ 2).
- SHIFT: each `sin_valid` shifts one bit in and increments the counter.
  - When the WIDTH-th data bit is shifted: go to PAR with PARITY_EN; otherwise the word completes and the state returns to IDLE.
- PAR (PARITY_EN only): the next `sin_valid` bit is the parity bit. The word completes and the state returns to IDLE.

`sync`:
- `sync && sin_valid` in any state discards the partial word.
- That cycle's bit is treated as bit 0 of a new word: counter = 1, state SHIFT.
- `sync` without `sin_valid` is ignored.

Word completion:
- If the output register is free (`!dout_valid`, or `dout_valid && dout_ready` on the same edge), the assembled word loads into `dout` and `dout_valid` = 1.
- Simultaneous accept and completion: the new word replaces the old one and `dout_valid` stays 1.
- If the output register is occupied and not accepted, the new word is dropped, `dout` is unchanged, and `overrun` pulses for exactly one cycle.

Other output-port rules:
- Accept without completion clears `dout_valid`. `dout` keeps its last value.
- `sin_valid` low: no state change; gaps of any length are legal mid-word.

## Timing

- Latency: the last bit (data or parity) is sampled at edge N; `dout`/`dout_valid` are high from edge N onward. No extra pipeline stage.
- `busy` is registered. It rises after the first bit's edge and falls at the completing edge.
- Asynchronous reset mid-word or mid-hold clears everything immediately; no partial word survives.
- The consumer may hold `dout_ready` high permanently; throughput is one word per WIDTH (or WIDTH+1) valid bits.

## Configuration

- SERIAL_DESER_PARITY_EN defined:
  - PAR state present; each word is WIDTH data bits followed by one even-parity bit.
  - `parity_err` = XOR of the data bits and the parity bit. It loads with `dout`, is meaningful while `dout_valid`, and resets to 0.
  - Words with bad parity are still delivered.
- Undefined: no PAR state, no `parity_err` port, and words are WIDTH bits.

## Structure

- Package `serial_deser_pkg`:
  - state enum (IDLE, SHIFT, PAR)
  - default WIDTH constant
  - counter-width function ($clog2(WIDTH+2))
- One natural sub-module, `deser_out_reg`: the output holding register. It owns the `dout`/`dout_valid` handshake, `overrun` generation and `parity_err` storage.
- Shift/count FSM stays in the top.

## Test plan

- Reset: drive bits, assert `rst_n` = 0 mid-word → all outputs 0 at once; after release, the next 8 bits form a clean word.
- WIDTH=8, LSB-first: bits 1,0,1,1,0,0,1,0 with `dout_ready` = 1 → `dout` = 8'h4D, `dout_valid` high for one cycle after the 8th edge.
- MSB_FIRST=1, same bits → `dout` = 8'hB2.
- Gaps and `sync`:
  - Insert `sin_valid` = 0 gaps of 3 cycles → same 8'h4D.
  - Send 5 bits, then `sync` with a new 8-bit word 8'hFF → `dout` = 8'hFF; the partial word never appears.
- Backpressure:
  - `dout_ready` = 0, send 8'h4D then 8'h12 → `dout` stays 8'h4D and `overrun` pulses once at the 16th bit.
  - Raise `dout_ready` on the completion edge of the second word → `dout` = 8'h12, no overrun, `dout_valid` stays 1.
- PARITY_EN: 8'h4D with parity bit 0 → `parity_err` = 0; with parity bit 1 → `parity_err` = 1, and the word is still delivered.
